// File: rtl/directory_arbiter.sv
// directory_arbiter: round-robin serialiser of four cache requesters onto a single
// directory put/get port, with at most one transaction outstanding.
module directory_arbiter #(
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH = 18,
   parameter int STATE_WIDTH = 2,
   localparam int ROW = STATE_WIDTH + TAG_WIDTH,
   localparam int ENTRY = 4 * ROW,
   localparam int PUT = INDEX_WIDTH + 1 + ROW + 2
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [3:0]               req_valid,
   output logic [3:0]               req_ready,
   input  logic [3:0]               req_write,
   input  logic [4*INDEX_WIDTH-1:0] req_idx,
   input  logic [4*ROW-1:0]         req_row,
   output logic [3:0]               resp_valid,
   input  logic [3:0]               resp_ready,
   output logic [ENTRY-1:0]         resp_entry,
   output logic                     dir_put_valid,
   input  logic                     dir_put_ready,
   output logic [PUT-1:0]           dir_put_request,
   output logic                     dir_get_valid,
   input  logic                     dir_get_ready,
   input  logic [ENTRY-1:0]         dir_get_response,
   output logic                     busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_GET, RESP} state_t;
   state_t state, nxt;
   logic [1:0] rr_ptr, gnt, g_q;
   logic [INDEX_WIDTH-1:0] idx_q;
   logic [ROW-1:0] row_q;
   logic wr_q;
   // lowest rotation offset from rr_ptr wins, so scan offsets high to low
   always_comb begin
      gnt = rr_ptr;
      for (int k = 3; k >= 0; k--)
         if (req_valid[rr_ptr + 2'(k)]) gnt = rr_ptr + 2'(k);
   end
   always_comb begin
      nxt = state;
      req_ready = '0;
      dir_put_valid = 1'b0;
      dir_get_valid = 1'b0;
      resp_valid = '0;
      case (state)
         IDLE: begin
            nxt = |req_valid ? ISSUE : IDLE;
            req_ready = (RST_N && |req_valid) ? 4'b0001 << gnt : 4'b0000;
         end
         ISSUE: begin
            dir_put_valid = 1'b1;
            nxt = dir_put_ready ? (wr_q ? IDLE : WAIT_GET) : ISSUE;
         end
         WAIT_GET: begin
            dir_get_valid = 1'b1;
            nxt = dir_get_ready ? RESP : WAIT_GET;
         end
         RESP: begin
            resp_valid = 4'b0001 << g_q;
            nxt = resp_ready[g_q] ? IDLE : RESP;
         end
      endcase
   end
   assign busy = state != IDLE;
   assign dir_put_request = {idx_q, wr_q, row_q, g_q[1], g_q[0]};
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         rr_ptr <= '0;
         g_q <= '0;
         idx_q <= '0;
         wr_q <= 1'b0;
         row_q <= '0;
         resp_entry <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && |req_valid) begin
            g_q <= gnt;
            rr_ptr <= gnt + 2'd1;
            idx_q <= req_idx[gnt*INDEX_WIDTH +: INDEX_WIDTH];
            wr_q <= req_write[gnt];
            row_q <= req_row[gnt*ROW +: ROW];
         end
         if (state == WAIT_GET && dir_get_ready) resp_entry <= dir_get_response;
      end
   end
endmodule

// File: tb/tb_directory_arbiter.sv
// tb_directory_arbiter: directed scenario tests for directory_arbiter with
// hand-computed expectations; the bench itself plays the directory.
module tb_directory_arbiter;
   localparam int IW = 12;
   localparam int RW = 20;
   localparam int EW = 80;
   localparam int PW = 35;
   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic [3:0] req_valid, req_ready, req_write, resp_valid, resp_ready;
   logic [4*IW-1:0] req_idx;
   logic [4*RW-1:0] req_row;
   logic [EW-1:0] resp_entry, dir_get_response;
   logic [PW-1:0] dir_put_request;
   logic dir_put_valid, dir_put_ready, dir_get_valid, dir_get_ready, busy;
   int passed = 0;
   int total = 0;

   always #5 CLK = ~CLK;

   directory_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_idx(req_idx), .req_row(req_row),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_entry(resp_entry),
      .dir_put_valid(dir_put_valid), .dir_put_ready(dir_put_ready), .dir_put_request(dir_put_request),
      .dir_get_valid(dir_get_valid), .dir_get_ready(dir_get_ready), .dir_get_response(dir_get_response),
      .busy(busy)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      logic [125:0] outs;
      req_valid = 4'b1111; req_write = 4'b0000; req_idx = '0; req_row = '0;
      resp_ready = 4'b1111; dir_put_ready = 1'b1; dir_get_ready = 1'b1; dir_get_response = '0;
      #2;
      outs = {req_ready, resp_valid, dir_put_valid, dir_get_valid, busy, resp_entry, dir_put_request};
      total++; if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else passed++;
      step();
      outs = {req_ready, resp_valid, dir_put_valid, dir_get_valid, busy, resp_entry, dir_put_request};
      total++; if (outs !== '0) $display("FAIL reset_after_edge: got %h want 0", outs); else passed++;
      req_valid = 4'b0000;
      RST_N = 1'b1;
      step();
   endtask

   task automatic test_single_read();
      req_valid = 4'b0010; req_write = 4'b0000;
      req_idx = {12'hEEE, 12'hDDD, 12'h05A, 12'hBBB};
      req_row = {20'hFFFFF, 20'hEEEEE, 20'h0ABCD, 20'hCCCCC};
      #1;
      total++; if (req_ready !== 4'b0010) $display("FAIL rd_grant: req_ready=%b want 0010", req_ready); else passed++;
      step();
      req_valid = 4'b0000;
      dir_get_response = 80'h11111_ABCDE_33333_44444;
      #1;
      total++; if ({dir_put_valid, dir_put_request} !== {1'b1, 12'h05A, 1'b0, 20'h0ABCD, 2'b01})
         $display("FAIL rd_put: got %b_%h want 1_%h", dir_put_valid, dir_put_request, {12'h05A, 1'b0, 20'h0ABCD, 2'b01}); else passed++;
      step();
      total++; if ({dir_get_valid, resp_valid, busy} !== {1'b1, 4'b0000, 1'b1})
         $display("FAIL rd_get: get=%b resp=%b busy=%b want 1 0000 1", dir_get_valid, resp_valid, busy); else passed++;
      step();
      total++; if (resp_valid !== 4'b0010) $display("FAIL rd_resp_valid: got %b want 0010", resp_valid); else passed++;
      total++; if (resp_entry !== 80'h11111_ABCDE_33333_44444) $display("FAIL rd_resp_entry: got %h want 11111abcde3333344444", resp_entry); else passed++;
      step();
      total++; if ({busy, resp_valid} !== 5'b0) $display("FAIL rd_done: busy=%b resp=%b want 0 0000", busy, resp_valid); else passed++;
   endtask

   task automatic test_write_read();
      req_valid = 4'b1000; req_write = 4'b1000;
      req_idx = {12'h100, 12'h222, 12'h333, 12'h444};
      req_row = {20'h81234, 60'h0};
      #1;
      total++; if (req_ready !== 4'b1000) $display("FAIL wr_grant: req_ready=%b want 1000", req_ready); else passed++;
      step();
      req_valid = 4'b0000;
      #1;
      total++; if ({dir_put_valid, dir_put_request} !== {1'b1, 12'h100, 1'b1, 20'h81234, 2'b11})
         $display("FAIL wr_put: got %b_%h want 1_%h", dir_put_valid, dir_put_request, {12'h100, 1'b1, 20'h81234, 2'b11}); else passed++;
      step();
      total++; if ({busy, resp_valid, dir_get_valid} !== 6'b0)
         $display("FAIL wr_done: busy=%b resp=%b get=%b want 0 0000 0", busy, resp_valid, dir_get_valid); else passed++;
      req_valid = 4'b1000; req_write = 4'b0000;
      step();
      req_valid = 4'b0000;
      dir_get_response = 80'h55555_66666_77777_81234;
      #1;
      total++; if (dir_put_request !== {12'h100, 1'b0, 20'h81234, 2'b11})
         $display("FAIL wr_rd_put: got %h want %h", dir_put_request, {12'h100, 1'b0, 20'h81234, 2'b11}); else passed++;
      step();
      step();
      total++; if ({resp_valid, resp_entry} !== {4'b1000, 80'h55555_66666_77777_81234})
         $display("FAIL wr_rd_resp: resp=%b entry=%h want 1000 55555666667777781234", resp_valid, resp_entry); else passed++;
      step();
   endtask

   task automatic test_fairness();
      logic [3:0] order [5];
      int n = 0;
      req_valid = 4'b1111; req_write = 4'b0000;
      dir_get_response = 80'h0F0F0;
      for (int c = 0; c < 60 && n < 5; c++) begin
         #1;
         if (req_ready !== 4'b0000) begin
            order[n] = req_ready;
            n++;
         end
         step();
      end
      req_valid = 4'b0000;
      total++; if (n !== 5) $display("FAIL fair_timeout: grants=%0d want 5", n); else passed++;
      for (int k = 0; k < n; k++) begin
         total++; if (order[k] !== 4'(1 << (k % 4))) $display("FAIL fair_order%0d: got %b want %b", k, order[k], 4'(1 << (k % 4))); else passed++;
      end
      for (int c = 0; c < 10 && busy; c++) step();
      total++; if (busy !== 1'b0) $display("FAIL fair_drain: busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_backpressure();
      dir_put_ready = 1'b0;
      req_valid = 4'b0100; req_write = 4'b0000;
      req_idx = {12'h000, 12'h3C3, 12'h000, 12'h011};
      req_row = {20'h0, 20'h5A5A5, 40'h0};
      #1;
      total++; if (req_ready !== 4'b0100) $display("FAIL bp_grant: req_ready=%b want 0100", req_ready); else passed++;
      step();
      req_valid = 4'b0101;
      req_idx[2*IW +: IW] = 12'hFFF;
      dir_get_response = 80'hDEAD_BEEF_0123_4567_89AB;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++; if ({dir_put_valid, dir_put_request, req_ready, busy} !== {1'b1, 12'h3C3, 1'b0, 20'h5A5A5, 2'b10, 4'b0000, 1'b1})
            $display("FAIL bp_put_hold%0d: put=%b req=%h ready=%b busy=%b", k, dir_put_valid, dir_put_request, req_ready, busy); else passed++;
         step();
      end
      dir_put_ready = 1'b1;
      resp_ready = 4'b0000;
      step();
      step();
      dir_get_response = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if ({resp_valid, resp_entry, req_ready, busy} !== {4'b0100, 80'hDEAD_BEEF_0123_4567_89AB, 4'b0000, 1'b1})
            $display("FAIL bp_resp_hold%0d: resp=%b entry=%h ready=%b busy=%b", k, resp_valid, resp_entry, req_ready, busy); else passed++;
         step();
      end
      resp_ready = 4'b1111;
      step();
      #1;
      total++; if (req_ready !== 4'b0001) $display("FAIL bp_pending_grant: req_ready=%b want 0001", req_ready); else passed++;
      step();
      req_valid = 4'b0000;
      for (int c = 0; c < 10 && busy; c++) step();
      total++; if (busy !== 1'b0) $display("FAIL bp_drain: busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_ignore_dropped();
      dir_put_ready = 1'b0;
      req_valid = 4'b0010; req_write = 4'b0010;
      req_idx = {12'h0, 12'h0, 12'h010, 12'h0};
      req_row = {40'h0, 20'h11111, 20'h0};
      #1;
      total++; if (req_ready !== 4'b0010) $display("FAIL ign_grant: req_ready=%b want 0010", req_ready); else passed++;
      step();
      req_valid = 4'b1000; req_write = 4'b0000;
      #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL ign_busy_ready: req_ready=%b want 0000", req_ready); else passed++;
      step();
      req_valid = 4'b0000;
      dir_put_ready = 1'b1;
      step();
      total++; if ({busy, req_ready} !== 5'b0) $display("FAIL ign_idle: busy=%b ready=%b want 0 0000", busy, req_ready); else passed++;
      step();
      total++; if (busy !== 1'b0) $display("FAIL ign_no_capture: busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_reset_mid_read();
      logic [125:0] outs;
      dir_get_ready = 1'b0;
      req_valid = 4'b0100; req_write = 4'b0000;
      req_idx = {12'h0, 12'h077, 24'h0};
      req_row = '0;
      #1;
      total++; if (req_ready !== 4'b0100) $display("FAIL mr_grant: req_ready=%b want 0100", req_ready); else passed++;
      step();
      req_valid = 4'b0000;
      step();
      total++; if (dir_get_valid !== 1'b1) $display("FAIL mr_wait_get: get=%b want 1", dir_get_valid); else passed++;
      #2;
      RST_N = 1'b0;
      #1;
      outs = {req_ready, resp_valid, dir_put_valid, dir_get_valid, busy, resp_entry, dir_put_request};
      total++; if (outs !== '0) $display("FAIL mr_async_reset: got %h want 0", outs); else passed++;
      step();
      RST_N = 1'b1;
      dir_get_ready = 1'b1;
      dir_get_response = 80'h1;
      req_valid = 4'b1001;
      req_idx = {12'h0, 24'h0, 12'h099};
      req_row = {60'h0, 20'h12345};
      #1;
      total++; if (req_ready !== 4'b0001) $display("FAIL mr_first_grant: req_ready=%b want 0001", req_ready); else passed++;
      step();
      req_valid = 4'b0000;
      #1;
      total++; if (dir_put_request !== {12'h099, 1'b0, 20'h12345, 2'b00})
         $display("FAIL mr_put: got %h want %h", dir_put_request, {12'h099, 1'b0, 20'h12345, 2'b00}); else passed++;
      step();
      step();
      total++; if (resp_valid !== 4'b0001) $display("FAIL mr_resp: resp=%b want 0001", resp_valid); else passed++;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_read();
      test_write_read();
      test_fairness();
      test_backpressure();
      test_ignore_dropped();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
